// File: rtl/l2_chan_interleaver.sv
// Splits accepted burst requests into per-channel fragments (interleave/partition).
// Optional per-channel fragment counters: define L2_INTERLEAVE_PERF_EN.
module l2_chan_interleaver #(
    parameter int unsigned          NumChannels     = 4,
    parameter int unsigned          AddrWidth       = 32,
    parameter int unsigned          IdWidth         = 6,
    parameter int unsigned          LenWidth        = 8,
    parameter int unsigned          BeatBytes       = 64,
    parameter int unsigned          InterleaveBeats = 8,
    parameter logic [AddrWidth-1:0] DramBase        = 32'h8000_0000,
    parameter logic [AddrWidth-1:0] DramSize        = 32'h0800_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         mode_i,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [AddrWidth-1:0]         req_addr_i,
    input  logic [LenWidth-1:0]          req_len_i,
    input  logic [IdWidth-1:0]           req_id_i,
    input  logic                         req_write_i,
    output logic [NumChannels-1:0]       chan_valid_o,
    input  logic [NumChannels-1:0]       chan_ready_i,
    output logic [AddrWidth-1:0]         chan_addr_o,
    output logic [LenWidth-1:0]          chan_len_o,
    output logic [IdWidth-1:0]           chan_id_o,
    output logic                         chan_write_o,
    output logic                         chan_last_o,
    output logic                         err_o,
    output logic                         busy_o,
    output logic [NumChannels-1:0][15:0] perf_cnt_o
);

    localparam int unsigned CL = $clog2(NumChannels);
    localparam int unsigned CW = (CL > 0) ? CL : 1;
    localparam int unsigned B  = $clog2(BeatBytes);
    localparam int unsigned G  = $clog2(BeatBytes * InterleaveBeats);
    localparam int unsigned RW = LenWidth + 1;
    localparam int unsigned EW = AddrWidth + RW + B + 1;

    localparam logic [AddrWidth-1:0] PartSize = DramSize / AddrWidth'(NumChannels);
    localparam logic [AddrWidth-1:0] GMask    = AddrWidth'((64'd1 << G) - 64'd1);
    localparam logic [AddrWidth-1:0] BMask    = AddrWidth'(BeatBytes - 1);
    localparam logic [AddrWidth-1:0] ChMask   = AddrWidth'(NumChannels - 1);
    localparam logic [EW-1:0]        DramLast = EW'(DramBase) + EW'(DramSize) - EW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, ERR} state_t;

    state_t                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [RW-1:0]          rem_q;
    logic [IdWidth-1:0]     id_q;
    logic                   write_q;
    logic                   mode_q;

    logic [AddrWidth-1:0]   off, il_loc, il_room, pt_loc, pt_room;
    logic [AddrWidth-1:0]   room, frag_loc;
    logic [CW-1:0]          frag_ch;
    logic [RW-1:0]          beats;
    logic [EW-1:0]          end_addr;
    logic                   req_bad, issue, req_fire, chan_fire;

    // Fragment geometry derives only from latched state, so outputs are glitch-free of ready.
    always_comb begin
        off     = addr_q - DramBase;
        il_loc  = ((off >> (G + CL)) << G) | (off & GMask);
        il_room = AddrWidth'(InterleaveBeats) - ((off & GMask) >> B);
        pt_loc  = off % PartSize;
        pt_room = (PartSize - pt_loc) >> B;
        if (mode_q) begin
            frag_ch  = CW'((off >> G) & ChMask);
            frag_loc = il_loc;
            room     = il_room;
        end else begin
            frag_ch  = CW'(off / PartSize);
            frag_loc = pt_loc;
            room     = pt_room;
        end
        beats = (room < AddrWidth'(rem_q)) ? RW'(room) : rem_q;
    end

    assign issue        = (state_q == ISSUE);
    assign chan_valid_o = issue ? (NumChannels'(1) << frag_ch) : '0;
    assign chan_addr_o  = issue ? frag_loc : '0;
    assign chan_len_o   = issue ? LenWidth'(beats - RW'(1)) : '0;
    assign chan_id_o    = issue ? id_q : '0;
    assign chan_write_o = issue && write_q;
    assign chan_last_o  = issue && (beats == rem_q);
    assign err_o        = (state_q == ERR);
    assign busy_o       = (state_q != IDLE);
    assign req_ready_o  = (state_q == IDLE) && !rst_i;
    assign req_fire     = req_valid_i && req_ready_o;
    assign chan_fire    = |(chan_valid_o & chan_ready_i);

    assign end_addr = EW'(req_addr_i) + ((EW'(req_len_i) + EW'(1)) << B) - EW'(1);
    assign req_bad  = (req_addr_i < DramBase) || (end_addr > DramLast)
                   || ((req_addr_i & BMask) != '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_fire) state_d = req_bad ? ERR : ISSUE;
            ISSUE:   if (chan_fire && chan_last_o) state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                addr_q  <= req_addr_i;
                rem_q   <= RW'(req_len_i) + RW'(1);
                id_q    <= req_id_i;
                write_q <= req_write_i;
                mode_q  <= mode_i;
            end else if (chan_fire) begin
                addr_q <= addr_q + (AddrWidth'(beats) << B);
                rem_q  <= rem_q - beats;
            end
        end
    end

`ifdef L2_INTERLEAVE_PERF_EN
    logic [NumChannels-1:0][15:0] perf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < NumChannels; i++) begin
                if (chan_valid_o[i] && chan_ready_i[i] && perf_q[i] != 16'hFFFF)
                    perf_q[i] <= perf_q[i] + 16'd1;
            end
        end
    end

    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = '0;
`endif

endmodule

// File: doc/l2_chan_interleaver.md
# l2_chan_interleaver

Splits wide-side memory requests across the `NumChannels` L2/DRAM channels. Each accepted burst request is mapped to a channel, translated to a channel-local offset, and split at interleave or partition boundaries into per-channel fragments. The block sits between the cluster AXI master mux and the per-channel L2 controllers. It replaces the fixed `addr[30:29]` channel select with a parametrised, runtime-selectable mapping.

## Interface
- `NumChannels`, 4: L2 channels; power of two, ≥1 (channel-select width C = max(1, log2 N)).
- `AddrWidth`, 32: address width.
- `IdWidth`, 6: request ID width.
- `LenWidth`, 8: AXI-style length (beats−1).
- `BeatBytes`, 64: bytes per beat (L2 bank width / 8); power of two.
- `InterleaveBeats`, 8: beats per interleave granule; power of two. Granule G = log2(BeatBytes·InterleaveBeats).
- `DramBase`, 32'h8000_0000: DRAM base.
- `DramSize`, 32'h0800_0000: total DRAM size; per-channel size P = DramSize/NumChannels.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `mode_i` in 1: 0 = partition, 1 = interleave. Sampled only at request accept.
- `req_valid_i` in 1 / `req_ready_o` out 1: request handshake.
- `req_addr_i` in AddrWidth; `req_len_i` in LenWidth; `req_id_i` in IdWidth; `req_write_i` in 1.
- `chan_valid_o` out N / `chan_ready_i` in N: per-channel fragment handshake.
- `chan_addr_o` out AddrWidth: channel-local byte offset. Shared by all channels; qualified by `chan_valid_o`.
- `chan_len_o` out LenWidth; `chan_id_o` out IdWidth; `chan_write_o` out 1: shared fragment fields.
- `chan_last_o` out 1: fragment is the last one of the original request.
- `err_o` out 1: one-cycle pulse when a request is dropped.
- `busy_o` out 1: FSM not in IDLE.
- `perf_cnt_o` out N×16: per-channel fragment counters (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, ERR.
- IDLE:
  - `req_ready_o`=1.
  - On handshake, latch addr, remaining beats = len+1, id, write and mode.
  - If the request is invalid, go to ERR; otherwise go to ISSUE.
- A request is invalid if any of the following holds:
  - addr < DramBase;
  - end address addr+(len+1)·BeatBytes−1 > DramBase+DramSize−1;
  - `addr % BeatBytes` ≠ 0.
- ERR: `err_o`=1 for exactly one cycle, no fragment is issued, then return to IDLE.
- ISSUE: the current offset is o = addr−DramBase, and b = log2(BeatBytes).
  - Interleave mode:
    - channel = o[G+C−1:G];
    - local = {o[AW−1:G+C], o[G−1:0]}, zero-extended;
    - fragment beats = min(remaining, InterleaveBeats − o[G−1:b]).
  - Partition mode:
    - channel = o / P;
    - local = o % P;
    - fragment beats = min(remaining, (P − local)/BeatBytes).
  - Exactly one `chan_valid_o` bit is set. `chan_len_o` = fragment beats − 1.
  - On handshake: addr += beats·BeatBytes and remaining −= beats. If remaining becomes 0 (`chan_last_o` was 1), go to IDLE; otherwise stay in ISSUE with the next fragment.
- `mode_i` changes while busy have no effect on the in-flight request.

## Timing
- Reset values: `req_ready_o`=0 during reset and 1 in the first cycle after reset; all other outputs 0; FSM in IDLE; counters 0.
- Accept at cycle t → first fragment valid at t+1 (registered outputs), or `err_o` at t+1.
- Throughput is one fragment per cycle under `chan_ready_i`=1.
- The next request is accepted no earlier than the cycle after the last fragment handshake. This gives a one-cycle bubble per request.
- Valid/data stability: once `chan_valid_o` is raised, it and all `chan_*` fields stay stable until the handshake. Valid must not depend combinationally on ready.
- Reset mid-operation drops the in-flight request. All valids are 0 in the cycle after `rst_i` is sampled high.
- Fragment beat arithmetic uses LenWidth+1 bits, so a 256-beat remaining count does not overflow.

## Configuration
- `L2_INTERLEAVE_PERF_EN` defined: `perf_cnt_o[i]` increments on each fragment handshake on channel i. Counters are 16-bit saturating at 16'hFFFF and cleared by `rst_i`.
- `L2_INTERLEAVE_PERF_EN` undefined: `perf_cnt_o` is tied to 0 and no counter flops are instantiated.

## Test plan
All scenarios use N=4, BeatBytes=64, InterleaveBeats=8 (G=9, granule 512 B), P=0x0200_0000.
- Interleave, addr 0x8000_0000, len 7 → one fragment: ch0, local 0x0, len 7, last=1, valid at cycle t+1.
- Interleave, addr 0x8000_0100, len 15 → three fragments:
  - ch0, local 0x100, len 3;
  - ch1, local 0x0, len 7;
  - ch2, local 0x0, len 3, last=1.
- Interleave channel wrap, addr 0x8000_0600, len 15 → ch3, local 0x0, len 7; then ch0, local 0x200, len 7, last=1.
- Partition, addr 0x81FF_FFC0, len 1 → ch0, local 0x01FF_FFC0, len 0; then ch1, local 0x0, len 0, last=1.
- Backpressure: hold `chan_ready_i`=0 for 5 cycles → fragment fields stable, `req_ready_o`=0, `busy_o`=1. Also assert `rst_i` mid-burst → all valids 0 next cycle and perf counters 0.
- Errors:
  - addr 0x7FFF_FFC0 → accepted, `err_o` pulse at t+1, no `chan_valid_o`;
  - addr 0x8000_0004 → same;
  - with the macro on, 70000 single-granule requests to ch0 → `perf_cnt_o[0]`=16'hFFFF.
